// File: rtl/fac_tower_pipe.sv
// Stallable, share-parallel tower-field factor generator: 2^LEVEL-bit shares in, 3^LEVEL-bit factor vectors out.
// Optional fresh remasking of the factor shares is enabled by defining FAC_TOWER_REFRESH_EN.
module fac_tower_pipe #(
    parameter int LEVEL   = 2,
    parameter int NSHARES = 2,
    parameter int PIPE    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NSHARES*(2**LEVEL)-1:0]        in_a,
`ifdef FAC_TOWER_REFRESH_EN
    input  logic [(NSHARES-1)*(3**LEVEL)-1:0]    rnd,
`endif
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NSHARES*(3**LEVEL)-1:0]        out_q,
    output logic                                 busy
);

    localparam int IW = 2**LEVEL;
    localparam int FW = 3**LEVEL;
    localparam int DW = NSHARES * FW;

    function automatic logic [2:0] fac1(input logic [1:0] x);
        return {x[1] ^ x[0], x[1], x[0]};
    endfunction

    function automatic logic [8:0] fac2(input logic [3:0] x);
        return {fac1(x[3:2] ^ x[1:0]), fac1(x[3:2]), fac1(x[1:0])};
    endfunction

    function automatic logic [26:0] fac3(input logic [7:0] x);
        return {fac2(x[7:4] ^ x[3:0]), fac2(x[7:4]), fac2(x[3:0])};
    endfunction

    if (LEVEL < 1 || LEVEL > 3) begin : g_bad_level
        $error("fac_tower_pipe: LEVEL must be 1, 2 or 3");
    end
    if (NSHARES < 1 || PIPE < 1) begin : g_bad_dims
        $error("fac_tower_pipe: NSHARES and PIPE must be at least 1");
    end

    logic [DW-1:0] fac_s;
    logic [DW-1:0] st0_s;

    // Each share is factored on its own slice; no logic spans two shares.
    for (genvar i = 0; i < NSHARES; i++) begin : g_share
        if (LEVEL == 1) begin : g_l1
            assign fac_s[i*FW +: FW] = fac1(in_a[i*IW +: IW]);
        end else if (LEVEL == 2) begin : g_l2
            assign fac_s[i*FW +: FW] = fac2(in_a[i*IW +: IW]);
        end else begin : g_l3
            assign fac_s[i*FW +: FW] = fac3(in_a[i*IW +: IW]);
        end
    end

`ifdef FAC_TOWER_REFRESH_EN
    if (NSHARES < 2) begin : g_bad_refresh
        $error("fac_tower_pipe: FAC_TOWER_REFRESH_EN needs NSHARES >= 2");
    end

    logic [FW-1:0] rnd_acc_s;

    // XOR of all mask slices, applied to the last share so the share sum is preserved.
    always_comb begin
        rnd_acc_s = '0;
        for (int i = 0; i < NSHARES - 1; i++) begin
            rnd_acc_s = rnd_acc_s ^ rnd[i*FW +: FW];
        end
    end

    for (genvar i = 0; i < NSHARES; i++) begin : g_refresh
        if (i < NSHARES - 1) begin : g_mid
            assign st0_s[i*FW +: FW] = fac_s[i*FW +: FW] ^ rnd[i*FW +: FW];
        end else begin : g_last
            assign st0_s[i*FW +: FW] = fac_s[i*FW +: FW] ^ rnd_acc_s;
        end
    end
`else
    assign st0_s = fac_s;
`endif

    logic [PIPE-1:0] valid_q;
    logic [PIPE-1:0] valid_d;
    logic [DW-1:0]   data_q [PIPE];
    logic [DW-1:0]   data_d [PIPE];
    logic            adv_s;

    // The whole pipe advances unless the output beat is stalled by the sink.
    always_comb begin
        adv_s = ~valid_q[PIPE-1] | out_ready;
    end

    // Next state: shift every stage on advance; bubbles carry zero data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_s) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? st0_s : '0;
            for (int s = 1; s < PIPE; s++) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage registers; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < PIPE; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < PIPE; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = valid_q[PIPE-1];
    assign out_q     = data_q[PIPE-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_fac_tower_pipe.sv
// Randomised scoreboard bench for fac_tower_pipe; factor model built from per-digit subset rules.
module tb_fac_tower_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output bit k (base-3 digits d_j) is the XOR of input bits n whose bit j is
    // 0 for d_j=0, 1 for d_j=1, and either for d_j=2.
    function automatic logic [63:0] mfac(input int lvl, input logic [63:0] x);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 0; k < 3**lvl; k++) begin
            for (int n = 0; n < 2**lvl; n++) begin
                int  t;
                bit  ok;
                t  = k;
                ok = 1'b1;
                for (int j = 0; j < lvl; j++) begin
                    int d;
                    d = t % 3;
                    t = t / 3;
                    if (d == 0 && ((n >> j) & 1) == 1) ok = 1'b0;
                    if (d == 1 && ((n >> j) & 1) == 0) ok = 1'b0;
                end
                if (ok) r[k] = r[k] ^ x[n];
            end
        end
        return r;
    endfunction

    function automatic logic [17:0] model2(input logic [7:0] a, input logic [8:0] r);
        logic [63:0] s0;
        logic [63:0] s1;
        s0 = mfac(2, {56'd0, 4'd0, a[3:0]});
        s1 = mfac(2, {56'd0, 4'd0, a[7:4]});
`ifdef FAC_TOWER_REFRESH_EN
        s0[8:0] = s0[8:0] ^ r;
        s1[8:0] = s1[8:0] ^ r;
`else
        if (r != 9'd0) s0 = s0;
`endif
        return {s1[8:0], s0[8:0]};
    endfunction

    // Main DUT: LEVEL=2, NSHARES=2, PIPE=3
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [7:0]  m_in_a = 8'd0;
    logic [8:0]  m_rnd = 9'd0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [17:0] m_out_q;
    logic        m_busy;

    fac_tower_pipe #(.LEVEL(2), .NSHARES(2), .PIPE(3)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a),
`ifdef FAC_TOWER_REFRESH_EN
        .rnd(m_rnd),
`endif
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_q(m_out_q), .busy(m_busy)
    );

`ifndef FAC_TOWER_REFRESH_EN
    // Single-share, single-stage DUTs for the literal vectors and the 8-bit sweep.
    logic        s_valid = 1'b0;
    logic        s_ready = 1'b1;
    logic [1:0]  s1_a = 2'd0;
    logic [3:0]  s2_a = 4'd0;
    logic [7:0]  s3_a = 8'd0;
    logic        s1_ir, s2_ir, s3_ir, s1_ov, s2_ov, s3_ov, s1_b, s2_b, s3_b;
    logic [2:0]  s1_q;
    logic [8:0]  s2_q;
    logic [26:0] s3_q;

    fac_tower_pipe #(.LEVEL(1), .NSHARES(1), .PIPE(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s1_ir), .in_a(s1_a),
        .out_valid(s1_ov), .out_ready(s_ready), .out_q(s1_q), .busy(s1_b));
    fac_tower_pipe #(.LEVEL(2), .NSHARES(1), .PIPE(1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s2_ir), .in_a(s2_a),
        .out_valid(s2_ov), .out_ready(s_ready), .out_q(s2_q), .busy(s2_b));
    fac_tower_pipe #(.LEVEL(3), .NSHARES(1), .PIPE(1)) u_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s3_ir), .in_a(s3_a),
        .out_valid(s3_ov), .out_ready(s_ready), .out_q(s3_q), .busy(s3_b));
`endif

    // Scoreboard for the main DUT, sampled on the falling edge.
    logic [17:0] exp_q [$];
    logic        prev_hold = 1'b0;
    logic [17:0] prev_q = 18'd0;
    int          emitted = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("in_ready_rule", {63'd0, m_in_ready}, {63'd0, (!m_out_valid) || m_out_ready});
            if (prev_hold) begin
                check("hold_valid", {63'd0, m_out_valid}, 64'd1);
                check("hold_stable", {46'd0, m_out_q}, {46'd0, prev_q});
            end
            if (m_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", {63'd0, m_out_valid}, 64'd0);
                end else begin
                    check("out_q", {46'd0, m_out_q}, {46'd0, exp_q[0]});
                    if (m_out_ready) begin
                        void'(exp_q.pop_front());
                        emitted++;
                    end
                end
            end
            if (m_in_valid && m_in_ready) exp_q.push_back(model2(m_in_a, m_rnd));
            prev_hold = m_out_valid && !m_out_ready;
            prev_q    = m_out_q;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int base;
        int budget;

        // Model pinned against hand-derived vectors.
        check("model_l2_B", mfac(2, 64'hB), 64'h173);
        check("model_l1_2", mfac(1, 64'h2), 64'h6);
        check("model_l3_FF", mfac(3, 64'hFF), 64'h361B);

        #2;
        check("rst_out_valid", {63'd0, m_out_valid}, 64'd0);
        check("rst_busy", {63'd0, m_busy}, 64'd0);
        check("rst_out_q", {46'd0, m_out_q}, 64'd0);
        check("rst_in_ready", {63'd0, m_in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Latency: {share1=0, share0=B} appears exactly 3 cycles after acceptance.
        m_in_valid = 1'b1; m_in_a = 8'h0B; m_rnd = 9'd0; m_out_ready = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick();
        check("lat_early", {63'd0, m_out_valid}, 64'd0);
        tick();
        check("lat_valid", {63'd0, m_out_valid}, 64'd1);
        check("lat_out_q", {46'd0, m_out_q}, 64'h00173);
        tick();
        check("lat_after", {63'd0, m_out_valid}, 64'd0);

        // Backpressure: 10 beats, sink stalls for 5 cycles mid-stream.
        base = emitted;
        sent = 0;
        budget = 0;
        while ((emitted - base < 10) && budget < 80) begin
            m_in_valid  = (sent < 10);
            m_in_a      = 8'($urandom);
`ifdef FAC_TOWER_REFRESH_EN
            m_rnd       = 9'($urandom);
`endif
            m_out_ready = !(budget >= 5 && budget < 10);
            #1;
            if (budget == 7) check("bp_in_ready_low", {63'd0, m_in_ready}, 64'd0);
            if (m_in_valid && m_in_ready) sent++;
            budget++;
            tick();
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        check("bp_delivered", 64'(emitted - base), 64'd10);
        tick();
        check("bp_busy_idle", {63'd0, m_busy}, 64'd0);

        // Random stream with random stalls.
        for (int c = 0; c < 300; c++) begin
            m_in_valid  = ($urandom % 4) != 0;
            m_in_a      = 8'($urandom);
`ifdef FAC_TOWER_REFRESH_EN
            m_rnd       = 9'($urandom);
`endif
            m_out_ready = ($urandom % 4) != 0;
            tick();
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        budget = 0;
        while (m_busy && budget < 20) begin
            budget++;
            tick();
        end
        check("drain_busy", {63'd0, m_busy}, 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        // Reset with 3 beats in flight.
        for (int b = 0; b < 3; b++) begin
            m_in_valid = 1'b1; m_in_a = 8'($urandom);
            tick();
        end
        m_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, m_out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, m_busy}, 64'd0);
        check("mid_rst_out_q", {46'd0, m_out_q}, 64'd0);
        check("mid_rst_in_ready", {63'd0, m_in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("post_rst_no_stale", {63'd0, m_out_valid}, 64'd0);
        end

`ifndef FAC_TOWER_REFRESH_EN
        // Literal vectors on the single-share instances.
        s_valid = 1'b1; s1_a = 2'b10; s2_a = 4'hB; s3_a = 8'hFF;
        tick();
        check("l1_valid", {63'd0, s1_ov}, 64'd1);
        check("l1_q", {61'd0, s1_q}, 64'h6);
        check("l2_q", {55'd0, s2_q}, 64'h173);
        check("l3_q_FF", {37'd0, s3_q}, 64'h361B);
        s3_a = 8'h00;
        tick();
        check("l3_q_00", {37'd0, s3_q}, 64'd0);
        for (int i = 0; i < 256; i++) begin
            s3_a = 8'(i);
            tick();
            check("l3_sweep", {37'd0, s3_q}, mfac(3, 64'(i)));
        end
        s_valid = 1'b0;
        tick();
        check("l3_idle", {63'd0, s3_ov}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fac_tower_pipe.md
Name: fac_tower_pipe

Overview:
- Pipelined, share-parallel generator of shared factors for masked tower-field (GF(2^2)/GF(2^4)/GF(256)) multiplier inputs.
- Generalises the 4-bit→9-bit factor sum to any tower level (2^LEVEL-bit input → 3^LEVEL-bit factor vector) and to NSHARES Boolean shares.
- Adds a valid/ready stream interface with a PIPE-deep stallable register pipeline.
- Sits between the masked S-box linear stages and the shared GF multipliers.

Parameters:
- LEVEL, 2, tower depth: 1 (2→3 bits), 2 (4→9 bits), 3 (8→27 bits). Other values are illegal; elaboration error.
- NSHARES, 2, number of Boolean shares (≥1). Each share is processed independently; the function is GF(2)-linear.
- PIPE, 1, register stages from input to output (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  NSHARES*2^LEVEL  shares; share i at [i*2^LEVEL +: 2^LEVEL].
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink accepts the beat.
- out_q  output  NSHARES*3^LEVEL  factor vectors; share i at [i*3^LEVEL +: 3^LEVEL].
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Factor function fac_L(x), recursive, MSB-first concatenation:
  - fac_1(x[1:0]) = {x1^x0, x1, x0}.
  - fac_L(x) = {fac_{L-1}(hi^lo), fac_{L-1}(hi), fac_{L-1}(lo)}, where hi/lo are the upper/lower halves of x.
  - L=2 is bit-identical to the existing 4-bit→9-bit factor block.
- Factoring is combinational at the input, before stage 0. Stages 1..PIPE-1 are pure delay.
- Each stage holds a valid bit and data. Global advance enable: adv = ~out_valid | out_ready.
- in_ready = adv. This is a combinational path from out_ready; it is permitted.
- A beat is accepted when in_valid & in_ready. On adv, every stage shifts one position; stage 0 valid loads in_valid.
- When adv=0, all stages hold and the input is not accepted.
- Latency is exactly PIPE cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Bubbles (in_valid=0) propagate as invalid stages. They are squeezed only at the output: adv holds while out_valid & ~out_ready.
- out_q is stable while out_valid & ~out_ready. This is required; verified by assertion.
- Reset (asynchronous assert, synchronous deassert at the driver):
  - All valid bits and all data registers clear to 0.
  - out_valid=0, out_q=0, busy=0, in_ready=1.
  - Reset mid-stream drops all in-flight beats; no partial beat appears after release.
- Shares never combine in the datapath: no XOR across share slices (masking requirement). Share slices stay in separate register bits.
- Simultaneous accept and emit in the same cycle is legal and must not lose or duplicate beats.

Optional Feature:
- Macro: FAC_TOWER_REFRESH_EN.
- Defined (requires NSHARES≥2):
  - Adds input port rnd (NSHARES-1)*3^LEVEL bits, sampled on acceptance.
  - At stage 0, factor share i (i<NSHARES-1) is XORed with rnd slice i. Share NSHARES-1 is XORed with the XOR of all rnd slices.
  - The XOR of the output shares is unchanged. Each output share is freshly remasked.
- Undefined: no rnd port; shares pass unrefreshed. Output equals fac_L applied per share.

Test Plan:
- LEVEL=2, NSHARES=1, PIPE=1: in_a=4'hB, out_ready=1 → next cycle out_valid=1, out_q=9'h173. LEVEL=1, in_a=2'b10 → out_q=3'b110.
- LEVEL=3, NSHARES=1: in_a=8'hFF → out_q=27'h000361B; in_a=8'h00 → 0. Sweep all 256 inputs against the recursive model.
- LEVEL=2, NSHARES=2, PIPE=3: shares {4'h0, 4'hB} → out_q={9'h000, 9'h173} after 3 cycles. Random shares: XOR of output slices = fac_2(XOR of input shares).
- Backpressure, PIPE=3: stream 10 beats; hold out_ready=0 for 5 cycles mid-stream:
  - in_ready=0 while out_valid is held.
  - out_q stable while held.
  - All 10 beats delivered in order, no loss or duplicates.
  - busy=0 after the last beat is emitted.
- Assert rst_n=0 with 3 beats in flight → out_valid, busy, and out_q go 0 immediately (asynchronous). After release, in_ready=1 and no stale beat emerges.
- With FAC_TOWER_REFRESH_EN, NSHARES=3: random rnd → XOR of outputs matches the unrefreshed model. rnd=0 → outputs identical to the build without the macro.
